rgb_arbiter: RTL and testbench
==============================

RGB_ARBITER -- requirements
Module: rgb_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, meaning read latency of the colour ROM in clk cycles; legal values 1 or 2.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_a  input  1  requester A lookup request; level, held until gnt_a.
REQ-005 colour_a  input  3  requester A colour index; sampled in the grant cycle.
REQ-006 req_b  input  1  requester B lookup request; level, held until gnt_b.
REQ-007 colour_b  input  3  requester B colour index; sampled in the grant cycle.
REQ-008 gnt_a, gnt_b  output  1 each  one-cycle grant pulse, combinational from current requests and priority state.
REQ-009 done_a, done_b  output  1 each  registered one-cycle pulse; the matching rgb_x is valid in this cycle.
REQ-010 rgb_a, rgb_b  output  24 each  registered lookup result; holds its value between done pulses.
REQ-011 mem_en  output  1  ROM enable; high only in a grant cycle.
REQ-012 mem_addr  output  3  ROM address; equals the granted colour when mem_en=1, otherwise 0.
REQ-013 mem_rdata  input  24  ROM read data; valid MEM_LAT cycles after the issue cycle.

Function
REQ-014 Arbitration: at most one grant per cycle; gnt_a and gnt_b are never high together.
REQ-015 Only req_a high: gnt_a=1. Only req_b high: gnt_b=1. Neither high: no grant and mem_en=0.
REQ-016 Both high: the requester named by the 1-bit priority pointer prio is granted (0=A, 1=B).
REQ-017 After any grant, prio is set to the non-granted requester; with no grant, prio is unchanged.
REQ-018 Issue: in a grant cycle N, mem_en=1 and mem_addr=granted colour_x.
REQ-019 Tag pipeline: each grant pushes {valid, owner} into a MEM_LAT+1 deep shift register; a non-grant cycle pushes valid=0.
REQ-020 Capture: when a tag exits the pipeline, rgb_owner is loaded from mem_rdata at the end of cycle N+MEM_LAT.
REQ-021 Response: done_owner=1 in cycle N+MEM_LAT+1; fixed grant-to-done latency is MEM_LAT+1 cycles (2 cycles at default).
REQ-022 Throughput: one lookup may issue every cycle; up to MEM_LAT+1 lookups in flight, and responses return in issue order.
REQ-023 Requester protocol: drop req_x, or present a new colour_x, in the cycle after gnt_x; a req_x still high there is a new request.
REQ-024 colour_x changes while req_x waits ungranted are permitted; only the grant-cycle value is used.
REQ-025 Starvation bound: with both requests held high, each requester is granted at least once every 2 cycles.
REQ-026 rgb_x of the non-responding requester is unchanged in every cycle.

Reset
REQ-027 rst_n=0 clears these immediately, with no clock needed: prio=0, all pipeline tags invalid, done_a=done_b=0, rgb_a=rgb_b=24'h000000.
REQ-028 While rst_n=0: gnt_a=gnt_b=0, mem_en=0, mem_addr=0, regardless of requests.
REQ-029 Lookups in flight at reset assertion are discarded; no done pulse results from them after rst_n returns to 1.
REQ-030 First rising clk edge with rst_n=1 may register a grant; requests pending across reset release are served normally.

Verification
REQ-031 MEM_LAT=1 and ROM entry 5=24'hFF00FF. req_a=1, colour_a=5 for one cycle. Required: gnt_a and mem_en=1, mem_addr=5 in cycle N; done_a=1 and rgb_a=24'hFF00FF in N+2.
REQ-032 Reset with both reqs held high for 4 cycles. Required: gnt order A,B,A,B; done order A,B,A,B at 2-cycle latency; gnt never coincident.
REQ-033 req_a held high continuously with colour_a stepped 0..7. Required: 8 consecutive gnt_a; rgb_a matches each ROM entry in issue order; rgb_b unchanged.
REQ-034 rst_n pulsed low mid-clock while two lookups are in flight. Required: outputs zero at once; no done_a or done_b after release; next request gets 2-cycle latency.
REQ-035 MEM_LAT=2, alternating A/B single requests. Required: grant-to-done latency = 3 cycles and rgb_x correct for each.
REQ-036 req_b waits ungranted behind A while colour_b changes 3 then 6. Required: mem_addr=6 in gnt_b cycle; rgb_b equals ROM entry 6.

Source files
------------

// File: rtl/rgb_arbiter.sv
// Two-requester colour lookup arbiter: alternating-priority grant, single ROM issue
// port, and an in-order tag pipeline that routes each ROM response back to its owner.
`timescale 1ns/1ps
module rgb_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [2:0]  colour_a,
  input  logic        req_b,
  input  logic [2:0]  colour_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        done_a,
  output logic        done_b,
  output logic [23:0] rgb_a,
  output logic [23:0] rgb_b,
  output logic        mem_en,
  output logic [2:0]  mem_addr,
  input  logic [23:0] mem_rdata
);

  logic               prio_q, prio_d;
  logic [MEM_LAT-1:0] tag_v_q, tag_v_d;
  logic [MEM_LAT-1:0] tag_o_q, tag_o_d;
  logic               done_a_q, done_a_d;
  logic               done_b_q, done_b_d;
  logic [23:0]        rgb_a_q, rgb_a_d;
  logic [23:0]        rgb_b_q, rgb_b_d;
  logic               gnt_a_s, gnt_b_s;
  logic               exit_v_s, exit_o_s;

  // Grant decode; reset forces every request-side output low.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (rst_n) begin
      if (req_a && req_b) begin
        if (prio_q) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b1;
        end
      end else if (req_a) begin
        gnt_a_s = 1'b1;
      end else if (req_b) begin
        gnt_b_s = 1'b1;
      end else begin
        gnt_a_s = 1'b0;
      end
    end else begin
      gnt_a_s = 1'b0;
    end
  end

  assign gnt_a    = gnt_a_s;
  assign gnt_b    = gnt_b_s;
  assign mem_en   = gnt_a_s | gnt_b_s;
  assign mem_addr = gnt_a_s ? colour_a : (gnt_b_s ? colour_b : 3'd0);

  // Priority pointer and tag shift register; the done/rgb flops form the last stage.
  always_comb begin
    prio_d  = prio_q;
    tag_v_d = tag_v_q;
    tag_o_d = tag_o_q;
    if (gnt_a_s) begin
      prio_d = 1'b1;
    end else if (gnt_b_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_o_d[i] = tag_o_q[i-1];
    end
    tag_v_d[0] = gnt_a_s | gnt_b_s;
    tag_o_d[0] = gnt_b_s;
  end

  assign exit_v_s = tag_v_q[MEM_LAT-1];
  assign exit_o_s = tag_o_q[MEM_LAT-1];

  // Capture ROM data for the tag leaving the pipeline; the other requester's rgb holds.
  always_comb begin
    done_a_d = exit_v_s & ~exit_o_s;
    done_b_d = exit_v_s &  exit_o_s;
    if (done_a_d) begin
      rgb_a_d = mem_rdata;
    end else begin
      rgb_a_d = rgb_a_q;
    end
    if (done_b_d) begin
      rgb_b_d = mem_rdata;
    end else begin
      rgb_b_d = rgb_b_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      tag_v_q  <= '0;
      tag_o_q  <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      rgb_a_q  <= 24'h000000;
      rgb_b_q  <= 24'h000000;
    end else begin
      prio_q   <= prio_d;
      tag_v_q  <= tag_v_d;
      tag_o_q  <= tag_o_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      rgb_a_q  <= rgb_a_d;
      rgb_b_q  <= rgb_b_d;
    end
  end

  assign done_a = done_a_q;
  assign done_b = done_b_q;
  assign rgb_a  = rgb_a_q;
  assign rgb_b  = rgb_b_q;

endmodule

// File: tb/tb_rgb_arbiter.sv
// Scoreboard bench for rgb_arbiter: one instance per legal ROM latency, shared stimulus,
// expected responses queued at issue and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_rgb_arbiter;

  typedef struct {
    logic        owner;
    logic [23:0] rgb;
    int          issue;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_a, req_b;
  logic [2:0] colour_a, colour_b;

  logic        g1a, g1b, d1a, d1b, en1;
  logic [23:0] r1a, r1b, rd1;
  logic [2:0]  ad1;
  logic        g2a, g2b, d2a, d2b, en2;
  logic [23:0] r2a, r2b, rd2, rd2_p;
  logic [2:0]  ad2;

  logic [23:0] rom [8];
  resp_t       sb[$];
  int          p1 = 0, p2 = 0;
  logic [23:0] e1a = 24'h0, e1b = 24'h0, e2a = 24'h0, e2b = 24'h0;
  logic        m_prio = 1'b0, m_gnt_a = 1'b0, m_gnt_b = 1'b0;
  logic [2:0]  exp_addr = 3'd0;
  logic        rel_pending = 1'b0;
  int          cyc = 0;
  int          tests = 0, fails = 0;

  rgb_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .colour_a(colour_a), .req_b(req_b),
    .colour_b(colour_b), .gnt_a(g1a), .gnt_b(g1b), .done_a(d1a), .done_b(d1b),
    .rgb_a(r1a), .rgb_b(r1b), .mem_en(en1), .mem_addr(ad1), .mem_rdata(rd1));

  rgb_arbiter #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .colour_a(colour_a), .req_b(req_b),
    .colour_b(colour_b), .gnt_a(g2a), .gnt_b(g2b), .done_a(d2a), .done_b(d2b),
    .rgb_a(r2a), .rgb_b(r2b), .mem_en(en2), .mem_addr(ad2), .mem_rdata(rd2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM models: one and two cycles of read latency.
  always @(posedge clk) begin
    rd1   <= rom[ad1];
    rd2_p <= rom[ad2];
    rd2   <= rd2_p;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_done1", {30'd0, d1a, d1b}, 32'd0);
    chk("rst_done2", {30'd0, d2a, d2b}, 32'd0);
    chk("rst_rgb1a", {8'd0, r1a}, 32'd0);
    chk("rst_rgb1b", {8'd0, r1b}, 32'd0);
    chk("rst_rgb2a", {8'd0, r2a}, 32'd0);
    chk("rst_rgb2b", {8'd0, r2b}, 32'd0);
    chk("rst_gnt", {28'd0, g1a, g1b, g2a, g2b}, 32'd0);
    chk("rst_mem", {24'd0, en1, ad1, en2, ad2}, 32'd0);
  endtask

  task automatic mon(input int lat, input logic da, input logic db,
                     input logic [23:0] ra, input logic [23:0] rb,
                     inout int p, inout logic [23:0] ea, inout logic [23:0] eb);
    resp_t e;
    while (p < sb.size() && sb[p].issue + lat + 1 < cyc) begin
      chk($sformatf("missing_done_L%0d", lat), 32'(cyc), 32'(sb[p].issue + lat + 1));
      p++;
    end
    chk($sformatf("done_excl_L%0d", lat), {31'd0, da & db}, 32'd0);
    if (da || db) begin
      if (p >= sb.size()) begin
        chk($sformatf("unexpected_done_L%0d", lat), {30'd0, da, db}, 32'd0);
      end else begin
        e = sb[p];
        p++;
        chk($sformatf("done_owner_L%0d", lat), {31'd0, db}, {31'd0, e.owner});
        chk($sformatf("latency_L%0d", lat), 32'(cyc - e.issue), 32'(lat + 1));
        if (e.owner) eb = e.rgb;
        else ea = e.rgb;
      end
    end
    chk($sformatf("rgb_a_L%0d", lat), {8'd0, ra}, {8'd0, ea});
    chk($sformatf("rgb_b_L%0d", lat), {8'd0, rb}, {8'd0, eb});
  endtask

  // Monitor: grant/issue checks against the model, response checks against the queue.
  always @(negedge clk) begin
    chk("gnt1", {30'd0, g1a, g1b}, {30'd0, m_gnt_a, m_gnt_b});
    chk("gnt2", {30'd0, g2a, g2b}, {30'd0, m_gnt_a, m_gnt_b});
    chk("mem1", {28'd0, en1, ad1}, {28'd0, m_gnt_a | m_gnt_b, exp_addr});
    chk("mem2", {28'd0, en2, ad2}, {28'd0, m_gnt_a | m_gnt_b, exp_addr});
    mon(1, d1a, d1b, r1a, r1b, p1, e1a, e1b);
    mon(2, d2a, d2b, r2a, r2b, p2, e2a, e2b);
  end

  // One cycle of stimulus plus the reference arbitration decision for that cycle.
  task automatic drive(input logic ra, input logic [2:0] ca, input logic rb, input logic [2:0] cb);
    resp_t e;
    @(posedge clk);
    #1;
    if (rel_pending) begin
      rst_n = 1'b1;
      rel_pending = 1'b0;
    end
    req_a = ra; colour_a = ca; req_b = rb; colour_b = cb;
    m_gnt_a = 1'b0;
    m_gnt_b = 1'b0;
    if (rst_n) begin
      if (ra && rb) begin
        if (m_prio) m_gnt_b = 1'b1;
        else m_gnt_a = 1'b1;
      end else if (ra) m_gnt_a = 1'b1;
      else if (rb) m_gnt_b = 1'b1;
    end
    if (m_gnt_a || m_gnt_b) begin
      exp_addr = m_gnt_b ? cb : ca;
      e.owner = m_gnt_b;
      e.rgb = rom[exp_addr];
      e.issue = cyc;
      sb.push_back(e);
      m_prio = m_gnt_a;
    end else begin
      exp_addr = 3'd0;
    end
  endtask

  // Assert reset mid-cycle, check outputs clear at once, discard everything in flight.
  task automatic do_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero();
    sb.delete();
    p1 = 0; p2 = 0;
    e1a = 24'h0; e1b = 24'h0; e2a = 24'h0; e2b = 24'h0;
    m_prio = 1'b0; m_gnt_a = 1'b0; m_gnt_b = 1'b0; exp_addr = 3'd0;
    repeat (hold) @(posedge clk);
    rel_pending = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    logic ra, rb;
    for (int i = 0; i < 8; i++) rom[i] = 24'($urandom);
    rom[5] = 24'hFF00FF;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; colour_a = 3'd0; colour_b = 3'd0;
    #1;
    chk_zero();
    rel_pending = 1'b1;

    drive(1'b1, 3'd5, 1'b0, 3'd0);
    idle(3);

    drive(1'b1, 3'd1, 1'b1, 3'd2);
    do_reset(2);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'(i), 1'b1, 3'(7 - i));
    idle(4);

    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0, 3'd0);
    idle(4);

    drive(1'b1, 3'd1, 1'b0, 3'd0);
    drive(1'b0, 3'd0, 1'b1, 3'd4);
    do_reset(1);
    drive(1'b1, 3'd2, 1'b0, 3'd0);
    idle(4);

    do_reset(1);
    drive(1'b1, 3'd0, 1'b1, 3'd3);
    drive(1'b0, 3'd0, 1'b1, 3'd6);
    idle(4);

    for (int i = 0; i < 400; i++) begin
      ra = (req_a && !m_gnt_a) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rb = (req_b && !m_gnt_b) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(ra, 3'($urandom_range(0, 7)), rb, 3'($urandom_range(0, 7)));
    end
    idle(6);
    @(posedge clk);
    #1;
    chk("drain_L1", 32'(p1), 32'(sb.size()));
    chk("drain_L2", 32'(p2), 32'(sb.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
